// File: rtl/veritune_pkg.sv
// Shared VeriTune constants: FFT geometry, magnitude width and peak-finder state encoding.
// The peak finder's optional threshold qualifier is enabled by defining VERITUNE_PEAK_THRESH_EN.
package veritune_pkg;
  localparam int FFT_N  = 1024;
  localparam int FFT_AW = 10;
  localparam int FFT_DW = 32;
  localparam int MAG_W  = 2 * FFT_DW;

  typedef enum logic [3:0] {
    PF_IDLE  = 4'b0001,
    PF_SCAN  = 4'b0010,
    PF_DRAIN = 4'b0100,
    PF_DONE  = 4'b1000
  } pf_state_e;
endpackage

// File: rtl/fft_mag_sq.sv
// Registered magnitude-squared of one complex FFT bin: mag = Re^2 + Im^2, one clock latency.
module fft_mag_sq
  import veritune_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic [2*DW-1:0]      mag
);

  logic signed [2*DW-1:0] re_x, im_x, re_sq, im_sq;
  logic [2*DW-1:0]        mag_d, mag_q;

  // Squares are non-negative and each is at most 2^(2*DW-2), so the unsigned sum never wraps.
  always_comb begin
    re_x  = {{DW{re[DW-1]}}, re};
    im_x  = {{DW{im[DW-1]}}, im};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    mag_d = $unsigned(re_sq) + $unsigned(im_sq);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mag_q <= '0;
    else        mag_q <= mag_d;
  end

  assign mag = mag_q;

endmodule

// File: rtl/fft_peak_finder.sv
// Scans FFT bins 1..N/2-1, tracks the largest Re^2+Im^2 and reports it via Start/Done/Ack.
// Define VERITUNE_PEAK_THRESH_EN to add the Thresh input that qualifies Peak_Valid.
module fft_peak_finder
  import veritune_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int AW = FFT_AW,
  parameter int DW = FFT_DW
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Ack,
  output logic [AW-1:0]        Rd_Addr,
  input  logic signed [DW-1:0] Rd_Re,
  input  logic signed [DW-1:0] Rd_Im,
`ifdef VERITUNE_PEAK_THRESH_EN
  input  logic [2*DW-1:0]      Thresh,
`endif
  output logic                 Busy,
  output logic                 Done,
  output logic [AW-1:0]        Peak_Bin,
  output logic [2*DW-1:0]      Peak_Mag,
  output logic                 Peak_Valid
);

  localparam int            MW       = 2 * DW;
  localparam logic [AW-1:0] LAST_BIN = AW'(N / 2 - 1);
  localparam logic [AW-1:0] FIRST_BIN = AW'(1);

  pf_state_e     state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]    drain_cnt_q, drain_cnt_d;
  logic          vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [AW-1:0] bin_p1_q, bin_p1_d, bin_p2_q, bin_p2_d;
  logic [MW-1:0] mag_p2;
  logic [AW-1:0] max_bin_q, max_bin_d;
  logic [MW-1:0] max_mag_q, max_mag_d;
  logic [AW-1:0] peak_bin_q, peak_bin_d;
  logic [MW-1:0] peak_mag_q, peak_mag_d;
  logic          peak_valid_q, peak_valid_d;
  logic          busy_q, busy_d, done_q, done_d;
`ifdef VERITUNE_PEAK_THRESH_EN
  logic [MW-1:0] thresh_q, thresh_d;
`endif

  // Stage p1 -> p2: magnitude register, aligned with bin_p2_q/vld_p2_q
  fft_mag_sq #(.DW(DW)) u_mag_sq (
    .clk   (Clk),
    .rst_n (Reset_n),
    .re    (Rd_Re),
    .im    (Rd_Im),
    .mag   (mag_p2)
  );

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    drain_cnt_d  = drain_cnt_q;
    max_bin_d    = max_bin_q;
    max_mag_d    = max_mag_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_valid_d = peak_valid_q;
`ifdef VERITUNE_PEAK_THRESH_EN
    thresh_d     = thresh_q;
`endif

    // Stage p0 -> p1: data for the address presented this cycle lands next edge
    vld_p1_d = (state_q == PF_SCAN);
    bin_p1_d = rd_addr_q;
    vld_p2_d = vld_p1_q;
    bin_p2_d = bin_p1_q;

    // Stage p2 -> max: strict compare keeps the lowest bin on ties
    if (vld_p2_q && (mag_p2 > max_mag_q)) begin
      max_bin_d = bin_p2_q;
      max_mag_d = mag_p2;
    end

    case (state_q)
      PF_IDLE: begin
        rd_addr_d = '0;
        if (Start) begin
          state_d   = PF_SCAN;
          rd_addr_d = FIRST_BIN;
          max_bin_d = FIRST_BIN;
          max_mag_d = '0;
`ifdef VERITUNE_PEAK_THRESH_EN
          thresh_d  = Thresh;
`endif
        end
      end
      PF_SCAN: begin
        if (rd_addr_q == LAST_BIN) begin
          state_d     = PF_DRAIN;
          rd_addr_d   = '0;
          drain_cnt_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      PF_DRAIN: begin
        // The last bin needs these cycles to clear the read, magnitude and compare stages.
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'd2) begin
          state_d    = PF_DONE;
          peak_bin_d = max_bin_q;
          peak_mag_d = max_mag_q;
`ifdef VERITUNE_PEAK_THRESH_EN
          peak_valid_d = (max_mag_q > thresh_q);
`else
          peak_valid_d = 1'b1;
`endif
        end
      end
      PF_DONE: begin
        if (Ack) state_d = PF_IDLE;
      end
      default: begin
        state_d   = PF_IDLE;
        rd_addr_d = '0;
      end
    endcase

    busy_d = (state_d == PF_SCAN) || (state_d == PF_DRAIN);
    done_d = (state_d == PF_DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= PF_IDLE;
      rd_addr_q    <= '0;
      drain_cnt_q  <= '0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      bin_p1_q     <= '0;
      bin_p2_q     <= '0;
      max_bin_q    <= '0;
      max_mag_q    <= '0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef VERITUNE_PEAK_THRESH_EN
      thresh_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      drain_cnt_q  <= drain_cnt_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      bin_p1_q     <= bin_p1_d;
      bin_p2_q     <= bin_p2_d;
      max_bin_q    <= max_bin_d;
      max_mag_q    <= max_mag_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_valid_q <= peak_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef VERITUNE_PEAK_THRESH_EN
      thresh_q     <= thresh_d;
`endif
    end
  end

  assign Rd_Addr    = rd_addr_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Peak_Bin   = peak_bin_q;
  assign Peak_Mag   = peak_mag_q;
  assign Peak_Valid = peak_valid_q;

endmodule
